// File: rtl/stepper_ramp_gen.sv
// Rate ramp generator for the 3-phase PWM stage. It slews the current rate toward a commanded
// target and turns that rate into single-cycle step pulses through a phase accumulator.
module stepper_ramp_gen #(
  parameter int RATE_W   = 16,
  parameter int ACC_W    = 24,
  parameter int ACCEL    = 16,
  parameter int RAMP_DIV = 1000,
  parameter int MAX_RATE = 40000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              cmd_dir,
  output logic              step_en,
  output logic              dir,
  output logic [RATE_W-1:0] cur_rate,
  output logic              at_speed,
  output logic              busy
);

  localparam int                CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [RATE_W-1:0] MAX_R    = RATE_W'(MAX_RATE);
  localparam logic [RATE_W:0]   STEP     = (RATE_W + 1)'(ACCEL);

  typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_FLIP} state_t;

  state_t            state, next_state;
  logic [RATE_W-1:0] tgt_rate;
  logic              tgt_dir;
  logic [CNT_W-1:0]  ramp_cnt;
  logic              tick;
  logic              accept;
  logic [RATE_W-1:0] eff;
  logic [RATE_W-1:0] next_rate;
  logic [RATE_W:0]   gap;
  logic [ACC_W-1:0]  acc;
  logic              carry;
  logic [ACC_W:0]    sum;

  assign accept = cmd_valid & cmd_ready;
  assign tick   = (ramp_cnt == CNT_LAST);
  // Opposite direction targets zero so a reversal always ramps down through rest first.
  assign eff    = (tgt_dir == dir) ? tgt_rate : '0;
  assign sum    = {1'b0, acc} + (ACC_W + 1)'(cur_rate);

  always_comb begin
    next_rate = cur_rate;
    gap       = '0;
    if (cur_rate < eff) begin
      gap       = {1'b0, eff} - {1'b0, cur_rate};
      next_rate = (gap > STEP) ? RATE_W'({1'b0, cur_rate} + STEP) : eff;
    end else if (cur_rate > eff) begin
      gap       = {1'b0, cur_rate} - {1'b0, eff};
      next_rate = (gap > STEP) ? RATE_W'({1'b0, cur_rate} - STEP) : eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_cnt <= '0;
    end else if (tick) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_rate <= '0;
      tgt_dir  <= 1'b0;
      cur_rate <= '0;
      dir      <= 1'b0;
      acc      <= '0;
      carry    <= 1'b0;
      step_en  <= 1'b0;
    end else begin
      if (accept) begin
        tgt_rate <= (cmd_rate > MAX_R) ? MAX_R : cmd_rate;
        tgt_dir  <= cmd_dir;
      end
      if (tick) begin
        cur_rate <= next_rate;
      end
      if (state == S_FLIP) begin
        dir <= tgt_dir;
      end
      acc     <= sum[ACC_W-1:0];
      carry   <= sum[ACC_W];
      step_en <= carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (state == S_FLIP) begin
      next_state = (tgt_rate == '0) ? S_IDLE : S_ACCEL;
    end else if ((cur_rate == '0) && (tgt_dir != dir)) begin
      next_state = S_FLIP;
    end else if (cur_rate < eff) begin
      next_state = S_ACCEL;
    end else if (cur_rate > eff) begin
      next_state = S_DECEL;
    end else if (cur_rate == '0) begin
      next_state = S_IDLE;
    end else begin
      next_state = S_CRUISE;
    end
  end

  always_comb begin
    cmd_ready = (state != S_FLIP);
    at_speed  = (state != S_FLIP) && (cur_rate == tgt_rate) && (dir == tgt_dir);
    busy      = ~at_speed;
  end

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Scoreboard bench for stepper_ramp_gen: stimulus queues the expected rate/direction sequence,
// and a monitor checks each observed cur_rate change against it.
module tb_stepper_ramp_gen;

  localparam int RATE_W   = 8;
  localparam int ACC_W    = 8;
  localparam int ACCEL    = 50;
  localparam int RAMP_DIV = 4;
  localparam int MAX_RATE = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [RATE_W-1:0] cmd_rate = '0;
  logic              cmd_dir = 1'b0;
  logic              cmd_ready;
  logic              step_en;
  logic              dir;
  logic [RATE_W-1:0] cur_rate;
  logic              at_speed;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int rate;
    int dir;
    bit gap_chk;
  } exp_t;

  exp_t exp_q[$];

  stepper_ramp_gen #(
    .RATE_W(RATE_W), .ACC_W(ACC_W), .ACCEL(ACCEL), .RAMP_DIV(RAMP_DIV), .MAX_RATE(MAX_RATE)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rate(cmd_rate), .cmd_dir(cmd_dir), .step_en(step_en), .dir(dir),
    .cur_rate(cur_rate), .at_speed(at_speed), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input int rate, input int d, input bit gap_chk);
    exp_t e;
    e.rate    = rate;
    e.dir     = d;
    e.gap_chk = gap_chk;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int rate, input int d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rate  = rate[RATE_W-1:0];
    cmd_dir   = d[0];
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitRate(input int target, input int budget);
    int n;
    n = 0;
    while (int'(cur_rate) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_rate", int'(cur_rate), target);
  endtask

  task automatic measureSteps(input int n, output int pulses, output int min_gap,
                              output int max_gap, output int doubles);
    int  last;
    bit  prev;
    pulses  = 0;
    min_gap = 1000;
    max_gap = 0;
    doubles = 0;
    last    = -1;
    prev    = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step_en) begin
        pulses++;
        if (prev) doubles++;
        if (last >= 0) begin
          if (i - last < min_gap) min_gap = i - last;
          if (i - last > max_gap) max_gap = i - last;
        end
        last = i;
      end
      prev = step_en;
    end
  endtask

  // Every cur_rate change outside reset must match the next queued expectation.
  initial begin : monitor
    int   last_rate;
    int   last_change;
    exp_t e;
    last_rate   = 0;
    last_change = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rate = 0;
      end else if (int'(cur_rate) != last_rate) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rate_seq actual=%0d expected=none", cur_rate);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rate_seq", int'(cur_rate), e.rate);
          checkOutput("dir_seq", int'(dir), e.dir);
          if (e.gap_chk) checkOutput("tick_gap", cyc - last_change, RAMP_DIV);
        end
        last_rate   = int'(cur_rate);
        last_change = cyc;
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int pulses, min_gap, max_gap, doubles;
    int low_cnt, first_low, dir_flip, dir_after, zero_pulses;

    repeat (3) @(negedge clk);
    checkOutput("rst_step_en", int'(step_en), 0);
    checkOutput("rst_cur_rate", int'(cur_rate), 0);
    checkOutput("rst_dir", int'(dir), 0);
    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rst_at_speed", int'(at_speed), 1);
    checkOutput("rst_busy", int'(busy), 0);
    #2 rst = 1'b0;
    measureSteps(100, pulses, min_gap, max_gap, doubles);
    checkOutput("idle_pulses", pulses, 0);

    // Ramp up to 128, then a carry every second cycle.
    pushExpect(50, 0, 1'b0);
    pushExpect(100, 0, 1'b1);
    pushExpect(128, 0, 1'b1);
    applyStimulus(128, 0);
    waitRate(100, 40);
    checkOutput("ramp_at_speed", int'(at_speed), 0);
    checkOutput("ramp_busy", int'(busy), 1);
    waitRate(128, 20);
    checkOutput("cruise_at_speed", int'(at_speed), 1);
    repeat (4) @(negedge clk);
    measureSteps(20, pulses, min_gap, max_gap, doubles);
    checkOutput("r128_pulses", pulses, 10);
    checkOutput("r128_min_gap", min_gap, 2);
    checkOutput("r128_max_gap", max_gap, 2);

    // Command above the clamp settles at MAX_RATE.
    pushExpect(178, 0, 1'b0);
    pushExpect(200, 0, 1'b1);
    applyStimulus(255, 0);
    waitRate(200, 40);
    repeat (40) @(negedge clk);
    checkOutput("clamp_rate", int'(cur_rate), 200);
    checkOutput("clamp_at_speed", int'(at_speed), 1);

    pushExpect(150, 0, 1'b0);
    pushExpect(128, 0, 1'b1);
    applyStimulus(128, 0);
    waitRate(128, 40);

    // Reversal ramps through zero with a single FLIP cycle.
    pushExpect(78, 0, 1'b0);
    pushExpect(28, 0, 1'b1);
    pushExpect(0, 0, 1'b1);
    pushExpect(50, 1, 1'b1);
    pushExpect(100, 1, 1'b1);
    pushExpect(128, 1, 1'b1);
    applyStimulus(128, 1);
    waitRate(0, 40);
    low_cnt     = 0;
    first_low   = -1;
    dir_flip    = -1;
    dir_after   = -1;
    zero_pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!cmd_ready) begin
        low_cnt++;
        if (first_low < 0) begin
          first_low = i;
          dir_flip  = int'(dir);
        end
      end
      if (first_low >= 0 && i == first_low + 1) dir_after = int'(dir);
      if (i >= 2 && cur_rate == '0 && step_en) zero_pulses++;
    end
    checkOutput("flip_cycles", low_cnt, 1);
    checkOutput("flip_position", first_low, 1);
    checkOutput("flip_dir_during", dir_flip, 0);
    checkOutput("flip_dir_after", dir_after, 1);
    checkOutput("zero_rate_pulses", zero_pulses, 0);
    waitRate(128, 40);
    checkOutput("rev_at_speed", int'(at_speed), 1);

    // Stop, then retarget to 60 while ramping toward 200.
    pushExpect(78, 1, 1'b0);
    pushExpect(28, 1, 1'b1);
    pushExpect(0, 1, 1'b1);
    applyStimulus(0, 1);
    waitRate(0, 40);
    checkOutput("stop_at_speed", int'(at_speed), 1);
    pushExpect(50, 1, 1'b0);
    applyStimulus(200, 1);
    waitRate(50, 20);
    pushExpect(60, 1, 1'b1);
    applyStimulus(60, 1);
    waitRate(60, 20);
    checkOutput("retarget_at_speed", int'(at_speed), 1);
    checkOutput("retarget_busy", int'(busy), 0);
    repeat (8) @(negedge clk);
    checkOutput("retarget_hold", int'(cur_rate), 60);

    // Rate 64 gives one step every four cycles.
    pushExpect(64, 1, 1'b0);
    applyStimulus(64, 1);
    waitRate(64, 20);
    repeat (4) @(negedge clk);
    measureSteps(400, pulses, min_gap, max_gap, doubles);
    checkOutput("r64_pulses", pulses, 100);
    checkOutput("r64_min_gap", min_gap, 4);
    checkOutput("r64_max_gap", max_gap, 4);
    checkOutput("r64_doubles", doubles, 0);

    // Asynchronous reset in the middle of a cruise.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_step_en", int'(step_en), 0);
    checkOutput("arst_cur_rate", int'(cur_rate), 0);
    checkOutput("arst_dir", int'(dir), 0);
    checkOutput("arst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("arst_at_speed", int'(at_speed), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    measureSteps(100, pulses, min_gap, max_gap, doubles);
    checkOutput("post_rst_pulses", pulses, 0);
    checkOutput("post_rst_rate", int'(cur_rate), 0);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
